// File: rtl/tcon_pkg.sv
// Shared defaults and sizing helpers for the tcon select/buffer pipeline.
package tcon_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_CNT_W = $clog2(DEF_DEPTH + 1);

   // Occupancy counter must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/tcon_fifo.sv
// Circular buffer with wrapping pointers and a separate occupancy counter.
module tcon_fifo
   import tcon_pkg::*;
#(
   parameter int W     = 2 * DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
   logic [AW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    push_ok, pop_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   // Full refuses a push even when a pop lands on the same edge.
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem_q[rptr_q];
   assign count   = cnt_q;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_ok) begin
         mem_d[wptr_q] = wdata;
         wptr_d        = wptr_q + AW'(1);
      end
      if (pop_ok) rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: rtl/tcon_pipe.sv
// Bitwise select of a_data/b_data, buffered alongside b_data in a small FIFO.
module tcon_pipe
   import tcon_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int MASK_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         a_data,
   input  logic [WIDTH-1:0]         b_data,
   input  logic [WIDTH-1:0]         sel,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [WIDTH-1:0]         pass_data,
   output logic [WIDTH-1:0]         mux_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [cnt_w(DEPTH)-1:0]  count
);
   logic [WIDTH-1:0]   mask, mux_w;
   logic [2*WIDTH-1:0] rdata;
   logic               full, empty;

   generate
      if (MASK_MODE != 0) begin : g_bitmask
         assign mask = sel;
      end else begin : g_wordmask
         assign mask = {WIDTH{sel[0]}};
      end
   endgenerate

   assign mux_w     = (a_data & mask) | (b_data & ~mask);
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign pass_data = rdata[2*WIDTH-1:WIDTH];
   assign mux_data  = rdata[WIDTH-1:0];

   tcon_fifo #(.W(2 * WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid && in_ready),
      .pop   (out_valid && out_ready),
      .wdata ({b_data, mux_w}),
      .rdata (rdata),
      .count (count),
      .full  (full),
      .empty (empty)
   );
endmodule

// File: doc/tcon_pipe.md
TCON_PIPE -- requirements
Module: tcon_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each data word (WIDTH >= 1).
REQ-002 SHALL have parameter DEPTH, default 4: number of buffer entries (power of two, DEPTH >= 2).
REQ-003 SHALL have parameter MASK_MODE, default 1: 1 = per-bit select from sel, 0 = sel[0] selects the whole word.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-006 SHALL have port a_data  input  WIDTH  alternate source word.
REQ-007 SHALL have port b_data  input  WIDTH  primary source word.
REQ-008 SHALL have port sel  input  WIDTH  select mask (bit=1 picks a_data bit).
REQ-009 SHALL have port in_valid  input  1  producer offers a_data/b_data/sel.
REQ-010 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-011 SHALL have port pass_data  output  WIDTH  buffered b_data of head entry.
REQ-012 SHALL have port mux_data  output  WIDTH  buffered select result of head entry.
REQ-013 SHALL have port out_valid  output  1  head entry present.
REQ-014 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL compute mux = (a_data & m) | (b_data & ~m), with m = sel when MASK_MODE=1 and m = {WIDTH{sel[0]}} when MASK_MODE=0; the result is captured at push time.
REQ-017 SHALL push {b_data, mux} when in_valid && in_ready, and pop the head when out_valid && out_ready.
REQ-018 SHALL drive in_ready = (count < DEPTH), combinationally from state only; it does not depend on out_ready (no pass-through when full).
REQ-019 SHALL drive out_valid = (count != 0); pass_data/mux_data come directly from the head entry and hold their value while out_valid && !out_ready.
REQ-020 SHALL give minimum latency of 1 cycle: a word pushed at edge N appears with out_valid=1 after edge N.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and keep order FIFO.
REQ-022 SHALL, on push into an empty buffer with out_ready=1, raise out_valid only in the next cycle; no bypass.
REQ-023 SHALL, when full, refuse the push (in_ready=0) even if a pop occurs in the same cycle.
REQ-024 SHALL use read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, with count tracked separately.
REQ-025 SHALL ignore a_data/b_data/sel when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear pointers and count to 0, giving out_valid=0, in_ready=1 and count=0 from the next cycle.
REQ-027 SHALL discard all buffered entries on reset mid-operation; pushes and pops in the reset cycle have no effect.
REQ-028 SHALL reset the storage array, so pass_data=0 and mux_data=0 after reset until the first push.

Structure
REQ-029 SHALL place the default WIDTH/DEPTH and the count-width helper constant in shared package tcon_pkg.
REQ-030 SHALL isolate the storage and pointers in one sub-module, tcon_fifo; the select logic stays in tcon_pipe.

Verification
REQ-031 SHALL cover: MASK_MODE=1, push a=8'hF0, b=8'h0F, sel=8'hCC -> after 1 cycle mux_data=8'hC3, pass_data=8'h0F, count=1.
REQ-032 SHALL cover: MASK_MODE=0, sel=8'h01, a=8'hAA, b=8'h55 -> mux_data=8'hAA; with sel=8'hFE -> mux_data=8'h55.
REQ-033 SHALL cover: out_ready=0, push 4 words -> count=4 and in_ready=0; a 5th offer is not accepted; then drain 4 words in push order.
REQ-034 SHALL cover: at count=2, push and pop in the same cycle -> count stays 2 and head advances by one word.
REQ-035 SHALL cover: at count=3, assert rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1, pass_data=mux_data=0.
REQ-036 SHALL cover: 20 words streamed with out_ready toggling randomly -> output sequence equals input sequence across pointer wrap.
